// File: rtl/gray_decoder_if.sv
// Sample/status bundle between an upstream Gray counter (master) and
// the gray_decoder receiver (slave).
interface gray_decoder_if #(
  parameter int WIDTH      = 3,
  parameter int WRAP_CNT_W = 8
);
  logic                  valid_i;
  logic                  clear_i;
  logic [WIDTH-1:0]      gray_i;
  logic [WIDTH-1:0]      binary_o;
  logic                  locked_o;
  logic                  wrap_o;
  logic                  error_o;
  logic [WRAP_CNT_W-1:0] wrap_count_o;

  modport master (
    output valid_i, clear_i, gray_i,
    input  binary_o, locked_o, wrap_o, error_o, wrap_count_o
  );

  modport slave (
    input  valid_i, clear_i, gray_i,
    output binary_o, locked_o, wrap_o, error_o, wrap_count_o
  );
endinterface

// File: rtl/gray_decoder.sv
// Gray-link receiver: decodes accepted samples, checks each is a hold or a
// single forward step, pulses on wrap and counts wraps (saturating).
module gray_decoder #(
  parameter int WIDTH      = 3,
  parameter int WRAP_CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  gray_decoder_if.slave link
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      binary_q;
  logic                  locked_q;
  logic                  wrap_q;
  logic                  error_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;

  logic [WIDTH-1:0]      dec_bin;
  logic [WIDTH-1:0]      binary_inc;
  logic [WRAP_CNT_W-1:0] wrap_cnt_d;

  // Each binary bit is the XOR of all Gray bits at or above it.
  assign dec_bin[WIDTH-1] = link.gray_i[WIDTH-1];
  generate
    for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_dec
      assign dec_bin[gi] = dec_bin[gi+1] ^ link.gray_i[gi];
    end
  endgenerate

  assign binary_inc = binary_q + 1'b1;
  assign wrap_cnt_d = (&wrap_cnt_q) ? wrap_cnt_q : wrap_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      binary_q   <= '0;
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      error_q    <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (link.clear_i) begin
        state_q    <= IDLE;
        binary_q   <= '0;
        locked_q   <= 1'b0;
        error_q    <= 1'b0;
        wrap_cnt_q <= '0;
      end else if (link.valid_i) begin
        case (state_q)
          IDLE: begin
            binary_q <= dec_bin;
            locked_q <= 1'b1;
            state_q  <= TRACK;
          end
          TRACK: begin
            if (dec_bin == binary_q) begin
              binary_q <= binary_q;
            end else if (dec_bin == binary_inc) begin
              binary_q <= dec_bin;
              if (&binary_q) begin
                wrap_q     <= 1'b1;
                wrap_cnt_q <= wrap_cnt_d;
              end
            end else begin
              // Binary keeps the last good value for post-mortem.
              error_q  <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= FAULT;
            end
          end
          default: state_q <= FAULT;
        endcase
      end
    end
  end

  assign link.binary_o     = binary_q;
  assign link.locked_o     = locked_q;
  assign link.wrap_o       = wrap_q;
  assign link.error_o      = error_q;
  assign link.wrap_count_o = wrap_cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder: directed scenarios plus random traffic, every
// cycle compared against a table-driven model of the link rules.
module tb_gray_decoder;
  localparam int WIDTH      = 3;
  localparam int WRAP_CNT_W = 2;
  localparam int NCODES     = 1 << WIDTH;
  localparam int MAXW       = (1 << WRAP_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  gray_decoder_if #(.WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W)) bus ();

  gray_decoder #(.WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: Gray->binary lookup built from n ^ (n >> 1).
  int g2b [NCODES];
  bit m_started, m_fault, m_wrap;
  int m_bin, m_wraps;

  function automatic logic [WIDTH-1:0] b2g(input int n);
    int m;
    m = n % NCODES;
    return WIDTH'(m ^ (m >> 1));
  endfunction

  function automatic void model_reset();
    m_started = 0; m_fault = 0; m_wrap = 0; m_bin = 0; m_wraps = 0;
  endfunction

  function automatic void model_step(input bit v, input bit c, input logic [WIDTH-1:0] g);
    int b;
    m_wrap = 0;
    if (c) begin
      model_reset();
    end else if (v && !m_fault) begin
      b = g2b[int'(g)];
      if (!m_started) begin
        m_started = 1;
        m_bin = b;
      end else if (b == (m_bin + 1) % NCODES) begin
        if (m_bin == NCODES - 1) begin
          m_wrap = 1;
          if (m_wraps < MAXW) m_wraps++;
        end
        m_bin = b;
      end else if (b != m_bin) begin
        m_fault = 1;
      end
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".binary"}, int'(bus.binary_o), m_bin);
    check({tag, ".locked"}, int'(bus.locked_o), int'(m_started && !m_fault));
    check({tag, ".wrap"}, int'(bus.wrap_o), int'(m_wrap));
    check({tag, ".error"}, int'(bus.error_o), int'(m_fault));
    check({tag, ".wrapcnt"}, int'(bus.wrap_count_o), m_wraps);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare.
  task automatic step(input string tag, input bit v, input bit c, input logic [WIDTH-1:0] g);
    bus.valid_i = v;
    bus.clear_i = c;
    bus.gray_i  = g;
    @(posedge clk);
    #1;
    model_step(v, c, g);
    $display("step %s v=%0b c=%0b g=%b -> bin=%0d lk=%0b wr=%0b er=%0b wc=%0d",
             tag, v, c, g, bus.binary_o, bus.locked_o, bus.wrap_o, bus.error_o, bus.wrap_count_o);
    check_all(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int n = 0; n < NCODES; n++) g2b[int'(b2g(n))] = n;
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.gray_i  = '0;
    model_reset();

    do_reset("t1.reset");
    for (int n = 0; n < NCODES; n++) step("t1.count", 1'b1, 1'b0, b2g(n));
    check("t1.bin7", int'(bus.binary_o), 7);

    step("t2.wrap", 1'b1, 1'b0, 3'b000);
    check("t2.wrap_pulse", int'(bus.wrap_o), 1);
    check("t2.wrapcnt1", int'(bus.wrap_count_o), 1);
    step("t2.idle", 1'b0, 1'b0, 3'b000);
    for (int n = 1; n <= 5 * NCODES; n++) step("t2.sat", 1'b1, 1'b0, b2g(n));
    check("t2.saturated", int'(bus.wrap_count_o), 3);

    do_reset("t3.reset");
    for (int n = 0; n <= 2; n++) step("t3.lead", 1'b1, 1'b0, b2g(n));
    repeat (3) step("t3.hold", 1'b1, 1'b0, 3'b011);
    repeat (2) step("t3.novalid", 1'b0, 1'b0, 3'b110);
    check("t3.bin2", int'(bus.binary_o), 2);

    do_reset("t4.reset");
    step("t4.s0", 1'b1, 1'b0, 3'b000);
    step("t4.s1", 1'b1, 1'b0, 3'b001);
    step("t4.jump", 1'b1, 1'b0, 3'b010);
    check("t4.err", int'(bus.error_o), 1);
    check("t4.keepbin", int'(bus.binary_o), 1);
    step("t4.ign1", 1'b1, 1'b0, 3'b011);
    step("t4.ign2", 1'b1, 1'b0, 3'b010);
    step("t4.clear", 1'b1, 1'b1, 3'b110);
    step("t4.first", 1'b1, 1'b0, 3'b110);
    check("t4.bin4", int'(bus.binary_o), 4);

    do_reset("t5.reset");
    step("t5.first", 1'b1, 1'b0, 3'b101);
    check("t5.bin6", int'(bus.binary_o), 6);
    step("t5.back", 1'b1, 1'b0, 3'b111);

    do_reset("t6.reset");
    for (int n = 0; n <= 2 * NCODES + 5; n++) step("t6.run", 1'b1, 1'b0, b2g(n));
    check("t6.pre_bin5", int'(bus.binary_o), 5);
    check("t6.pre_wc2", int'(bus.wrap_count_o), 2);
    do_reset("t6.async");
    repeat (2) step("t6.wait", 1'b0, 1'b0, 3'b111);
    step("t6.first", 1'b1, 1'b0, 3'b111);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [WIDTH-1:0] g;
      bit v, c;
      r = int'($urandom_range(0, 9));
      if (r < 5)      g = b2g(m_bin + 1);
      else if (r < 8) g = b2g(m_bin);
      else            g = WIDTH'($urandom_range(0, NCODES - 1));
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 29) == 0);
      step("rand", v, c, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
Receiving end of the 3-bit Gray counter link. It samples a Gray-coded count when Valid is high and decodes it to binary. It checks that every accepted sample is either a hold or a single legal forward step, and it flags wrap-around (the receiver-side counterpart of the counter's Overflow). It sits downstream of the Gray counter and feeds binary count plus link-health status to control/monitor logic.

Parameters:
WIDTH, 3, Gray/binary code width
WRAP_CNT_W, 8, width of the saturating wrap counter

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Valid  input  1  Gray sample valid this cycle
Clear  input  1  synchronous fault/statistics clear, active-high
Gray  input  WIDTH  Gray-coded count from upstream counter
Binary  output  WIDTH  registered decoded count (last accepted good value)
Locked  output  1  high once a first sample is accepted and no fault present
Wrap  output  1  one-cycle pulse on legal step from all-ones to zero
Error  output  1  sticky illegal-transition flag
WrapCount  output  WRAP_CNT_W  number of wraps since reset/Clear, saturating

Behaviour:
- Interface: one clock (Clk); Reset is asynchronous and active-high. Asserting Reset immediately forces state IDLE, Binary=0, Locked=0, Wrap=0, Error=0, WrapCount=0, with no clock edge needed.
- Decode (combinational, internal): d[WIDTH-1]=Gray[WIDTH-1]; d[i]=d[i+1]^Gray[i] for i=WIDTH-2..0.
- All outputs registered. Latency is 1 cycle: a sample at edge N appears on outputs after edge N.
- Wrap defaults to 0 every cycle. It is high only in the cycle after a wrapping sample.
- FSM states: IDLE, TRACK, FAULT.
- Priority, highest first: Reset (async), then Clear, then Valid.
- Clear, in any state: next state IDLE, Binary=0, Locked=0, Error=0, Wrap=0, WrapCount=0. A Valid sample in the same cycle is discarded.
- IDLE, Valid=1: Binary<=d, Locked<=1, go to TRACK. The first sample is never checked, so any code is accepted and no Wrap is raised.
- TRACK, Valid=1, d==Binary (hold): no change, no Error.
- TRACK, Valid=1, d==(Binary+1) mod 2^WIDTH: Binary<=d.
  - If Binary was all-ones, also Wrap<=1 and WrapCount<=WrapCount+1.
  - WrapCount saturates at 2^WRAP_CNT_W-1 and never rolls over.
- TRACK, Valid=1, any other d (backward step, multi-step jump): Error<=1, Locked<=0, go to FAULT. Binary keeps the last good value.
- FAULT: Valid ignored. All outputs hold, Wrap=0. Exit only via Clear or Reset.
- Valid=0 in any state: state, Binary, Error, Locked and WrapCount held; Wrap=0.
- Gray/Valid are synchronous to Clk. No internal synchronizer is required.

Test Plan:
1. Reset, then Valid=1 with Gray 000,001,011,010,110,111,101,100 on consecutive cycles -> Binary 0..7 one cycle after each sample; Locked=1 after first edge; Error=0; Wrap=0 throughout.
2. Continue 100 -> 000 -> Binary=0, Wrap=1 for exactly one cycle, WrapCount=1. With WRAP_CNT_W=2, run 5 full cycles -> WrapCount sticks at 3.
3. In TRACK at Binary=2, present 011 for 3 cycles, then Valid=0 for 2 cycles -> Binary stays 2, Error=0, Locked=1.
4. At Binary=1 (Gray 001), present 010 (binary 3) -> Error=1, Locked=0, Binary=1. Then legal 011/010 samples -> no change. Pulse Clear together with Valid/Gray=110 -> Error=0, Locked=0, WrapCount=0, sample discarded. Next Valid with Gray=110 -> Binary=4, Locked=1.
5. First sample after reset is 101 -> Binary=6, Locked=1, no Error. Next sample 111 (binary 5, backward) -> Error=1.
6. Assert Reset between clock edges mid-stream at Binary=5, WrapCount=2 -> all outputs 0 before the next rising edge. Release Reset -> IDLE, waits for the first Valid sample.
